train_seq: RTL and testbench

Parametrised training-pass sequencer for the on-chip learning datapath. It sequences forward passes over `NUM_LAYERS` layers, then backward passes in reverse layer order, then a one-cycle weight-update phase, and repeats for up to `MAX_EPOCHS` epochs. Each pass is started and completed through a start/done handshake with the layer datapath. It succeeds the fixed two-forward/one-backward controller, adding layer indexing, epoch counting, abort, and optional early stop on zero loss.

---
 rtl/train_seq_pkg.sv | 19 +
 rtl/train_seq_ctr.sv | 52 +++++
 rtl/train_seq.sv | 209 ++++++++++++++++++++
 tb/tb_train_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/train_seq_pkg.sv
// train_seq_pkg: shared types and helpers for the training-pass sequencer.
//   state_e   : sequencer state encoding (3 bits; codes 5..7 are unused)
//   cnt_width : width needed for a counter that must hold values 0..n-1 (minimum 1 bit)
package train_seq_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StFwd  = 3'd1,
    StBwd  = 3'd2,
    StUpd  = 3'd3,
    StDone = 3'd4
  } state_e;

  function automatic int unsigned cnt_width(int unsigned n);
    if (n < 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/train_seq_ctr.sv
// train_seq_ctr: loadable up/down counter that saturates at 0 and at MaxVal.
// Priority: clear, then load, then increment, then decrement.
//   clk_i      : clock
//   rst_i      : asynchronous active-low reset (counter -> 0)
//   clr_i      : synchronous clear to 0
//   load_i     : load load_val_i
//   load_val_i : value to load
//   inc_i      : count up (held at MaxVal)
//   dec_i      : count down (held at 0)
//   cnt_o      : current count
module train_seq_ctr #(
  parameter int unsigned Width  = 2,
  parameter int unsigned MaxVal = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [Width-1:0] Max = Width'(MaxVal);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != Max)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/train_seq.sv
// train_seq: training-pass sequencer. Runs forward passes over layers 0..NUM_LAYERS-1,
// backward passes over NUM_LAYERS-1..0, then a one-cycle weight update, for MAX_EPOCHS
// epochs. Each pass is opened with pass_start_o and closed by pass_done_i.
// Optional build macro TRAIN_SEQ_EARLY_STOP_EN: a zero loss at the end of the last forward
// pass skips the backward passes and ends the run after that epoch's update.
//   clk_i, rst_i (async, active-low), en_i (global hold)
//   init_i (start run, IDLE/DONE only), abort_i (sync return to IDLE, highest priority)
//   pass_done_i, loss_zero_i (datapath status)
//   fwd_o, bwd_o, layer_o, pass_start_o : current pass
//   zero_loss_o, weight_update_o        : one-cycle pulses in the update cycle
//   epoch_o (completed epochs), busy_o, done_o
module train_seq
  import train_seq_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned MAX_EPOCHS = 4,
  parameter int unsigned LAYER_W    = cnt_width(NUM_LAYERS),
  parameter int unsigned EPOCH_W    = cnt_width(MAX_EPOCHS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               init_i,
  input  logic               abort_i,
  input  logic               pass_done_i,
  input  logic               loss_zero_i,
  output logic               fwd_o,
  output logic               bwd_o,
  output logic [LAYER_W-1:0] layer_o,
  output logic               pass_start_o,
  output logic               zero_loss_o,
  output logic               weight_update_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [LAYER_W-1:0] LastLayer = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [EPOCH_W-1:0] LastEpoch = EPOCH_W'(MAX_EPOCHS - 1);

  state_e state_q, state_d;
  logic   start_q, start_d;
  logic   fwd_q, bwd_q, upd_q, busy_q, done_q;

  logic [LAYER_W-1:0] layer_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic layer_clr, layer_load, layer_inc, layer_dec;
  logic epoch_clr, epoch_inc;

  logic pass_ok, fwd_last_done;
  logic early_fwd, early_upd;

  // A done raised in the pass's own start cycle belongs to the previous pass.
  assign pass_ok       = pass_done_i && !start_q;
  assign fwd_last_done = (state_q == StFwd) && pass_ok && (layer_q == LastLayer);

`ifdef TRAIN_SEQ_EARLY_STOP_EN
  logic conv_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      conv_q <= 1'b0;
    end else if (en_i) begin
      if (abort_i) begin
        conv_q <= 1'b0;
      end else if (fwd_last_done) begin
        conv_q <= loss_zero_i;
      end
    end
  end

  // The branch at the end of forward uses the value being latched this edge.
  assign early_fwd = loss_zero_i;
  assign early_upd = conv_q;
`else
  logic unused_loss_zero;
  assign unused_loss_zero = loss_zero_i;
  assign early_fwd        = 1'b0;
  assign early_upd        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    layer_clr  = 1'b0;
    layer_load = 1'b0;
    layer_inc  = 1'b0;
    layer_dec  = 1'b0;
    epoch_clr  = 1'b0;
    epoch_inc  = 1'b0;
    if (en_i) begin
      if (abort_i) begin
        state_d   = StIdle;
        layer_clr = 1'b1;
        epoch_clr = 1'b1;
      end else begin
        case (state_q)
          StIdle, StDone: begin
            if (init_i) begin
              state_d   = StFwd;
              layer_clr = 1'b1;
              epoch_clr = 1'b1;
              start_d   = 1'b1;
            end
          end
          StFwd: begin
            if (fwd_last_done) begin
              if (early_fwd) begin
                state_d = StUpd;
              end else begin
                state_d    = StBwd;
                layer_load = 1'b1;
                start_d    = 1'b1;
              end
            end else if (pass_ok) begin
              layer_inc = 1'b1;
              start_d   = 1'b1;
            end
          end
          StBwd: begin
            if (pass_ok) begin
              if (layer_q != '0) begin
                layer_dec = 1'b1;
                start_d   = 1'b1;
              end else begin
                state_d = StUpd;
              end
            end
          end
          StUpd: begin
            epoch_inc = 1'b1;
            if ((epoch_q == LastEpoch) || early_upd) begin
              state_d = StDone;
            end else begin
              state_d   = StFwd;
              layer_clr = 1'b1;
              start_d   = 1'b1;
            end
          end
          default: begin
            state_d   = StIdle;
            layer_clr = 1'b1;
            epoch_clr = 1'b1;
          end
        endcase
      end
    end
  end

  // Outputs are decoded from the next state so they are flops, not decode logic.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      fwd_q   <= 1'b0;
      bwd_q   <= 1'b0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (en_i) begin
      state_q <= state_d;
      start_q <= start_d;
      fwd_q   <= (state_d == StFwd);
      bwd_q   <= (state_d == StBwd);
      upd_q   <= (state_d == StUpd);
      busy_q  <= (state_d == StFwd) || (state_d == StBwd) || (state_d == StUpd);
      done_q  <= (state_d == StDone);
    end
  end

  train_seq_ctr #(
    .Width  (LAYER_W),
    .MaxVal (NUM_LAYERS - 1)
  ) u_layer_ctr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (layer_clr),
    .load_i     (layer_load),
    .load_val_i (LastLayer),
    .inc_i      (layer_inc),
    .dec_i      (layer_dec),
    .cnt_o      (layer_q)
  );

  train_seq_ctr #(
    .Width  (EPOCH_W),
    .MaxVal (MAX_EPOCHS)
  ) u_epoch_ctr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (epoch_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (epoch_inc),
    .dec_i      (1'b0),
    .cnt_o      (epoch_q)
  );

  assign fwd_o           = fwd_q;
  assign bwd_o           = bwd_q;
  assign layer_o         = layer_q;
  assign pass_start_o    = start_q;
  assign zero_loss_o     = upd_q;
  assign weight_update_o = upd_q;
  assign epoch_o         = epoch_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule

// File: tb/tb_train_seq.sv
// Bench for train_seq: two instances (2 layers/2 epochs and 1 layer/1 epoch) share stimulus.
// A schedule-based model predicts every output on every cycle; directed phases add literal
// expectations, followed by a randomized phase.
module tb_train_seq;

`ifdef TRAIN_SEQ_EARLY_STOP_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b1;
  logic en = 1'b1, init = 1'b0, abort = 1'b0, pd = 1'b0, lz = 1'b0;

  logic       a_fwd, a_bwd, a_start, a_zl, a_wu, a_busy, a_done;
  logic [0:0] a_layer;
  logic [1:0] a_epoch;
  logic       b_fwd, b_bwd, b_start, b_zl, b_wu, b_busy, b_done;
  logic [0:0] b_layer;
  logic [0:0] b_epoch;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  train_seq #(.NUM_LAYERS(2), .MAX_EPOCHS(2)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .init_i(init), .abort_i(abort),
    .pass_done_i(pd), .loss_zero_i(lz), .fwd_o(a_fwd), .bwd_o(a_bwd), .layer_o(a_layer),
    .pass_start_o(a_start), .zero_loss_o(a_zl), .weight_update_o(a_wu), .epoch_o(a_epoch),
    .busy_o(a_busy), .done_o(a_done)
  );

  train_seq #(.NUM_LAYERS(1), .MAX_EPOCHS(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .init_i(init), .abort_i(abort),
    .pass_done_i(pd), .loss_zero_i(lz), .fwd_o(b_fwd), .bwd_o(b_bwd), .layer_o(b_layer),
    .pass_start_o(b_start), .zero_loss_o(b_zl), .weight_update_o(b_wu), .epoch_o(b_epoch),
    .busy_o(b_busy), .done_o(b_done)
  );

  // Model: an epoch is a list of 2n+1 slots (n forward, n backward, one update).
  typedef struct packed {
    bit act;   // running
    bit fin;   // finished (DONE)
    bit st;    // start pulse visible
    bit conv;  // loss was zero at last forward end
    int slot;
    int lay;
    int ep;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, int n, int mx, bit e, bit ini, bit ab, bit d,
                                 bit z);
    mdl_t r;
    r = m;
    if (!e) return m;
    r.st = 1'b0;
    if (ab) return '0;
    if (!m.act) begin
      if (ini) begin
        r = '0;
        r.act = 1'b1;
        r.st  = 1'b1;
      end
    end else if (m.slot == 2 * n) begin
      r.ep = m.ep + 1;
      if (r.ep == mx || (Early && m.conv)) begin
        r.act = 1'b0;
        r.fin = 1'b1;
      end else begin
        r.slot = 0;
        r.lay  = 0;
        r.st   = 1'b1;
      end
    end else if (d && !m.st) begin
      if (m.slot == n - 1) r.conv = z;
      if (Early && m.slot == n - 1 && z) r.slot = 2 * n;
      else r.slot = m.slot + 1;
      if (r.slot < 2 * n) begin
        r.lay = (r.slot < n) ? r.slot : 2 * n - 1 - r.slot;
        r.st  = 1'b1;
      end
    end
    return r;
  endfunction

  // {fwd, bwd, start, zero_loss, weight_update, busy, done}
  function automatic int mouts(mdl_t m, int n);
    logic [6:0] v;
    logic       u;
    u = m.act && (m.slot == 2 * n);
    v = {m.act && (m.slot < n), m.act && (m.slot >= n) && (m.slot < 2 * n), m.st, u, u,
         m.act, m.fin};
    return int'(v);
  endfunction

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp,
               $time);
    end
  endfunction

  function automatic int a_ctl();
    return int'({a_fwd, a_bwd, a_start, a_zl, a_wu, a_busy, a_done});
  endfunction

  function automatic int b_ctl();
    return int'({b_fwd, b_bwd, b_start, b_zl, b_wu, b_busy, b_done});
  endfunction

  // Step the models on each edge, then compare shortly after it.
  always @(posedge clk) begin
    if (!rst_n) begin
      ma = '0;
      mb = '0;
    end else begin
      ma = mstep(ma, 2, 2, en, init, abort, pd, lz);
      mb = mstep(mb, 1, 1, en, init, abort, pd, lz);
    end
    #1;
    chk("a_ctl", a_ctl(), mouts(ma, 2));
    chk("a_layer", int'(a_layer), ma.lay);
    chk("a_epoch", int'(a_epoch), ma.ep);
    chk("b_ctl", b_ctl(), mouts(mb, 1));
    chk("b_layer", int'(b_layer), mb.lay);
    chk("b_epoch", int'(b_epoch), mb.ep);
  end

  task automatic step();
    @(negedge clk);
  endtask

  // {fwd, bwd, start, weight_update, done} per cycle with pass_done held high.
  int ta [9] = '{'b10100, 'b10000, 'b10100, 'b10000, 'b01100, 'b01000, 'b01100, 'b01000,
                 'b00010};
  int la [9] = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
  int tbx[9] = '{'b10100, 'b10000, 'b01100, 'b01000, 'b00010, 'b00001, 'b00001, 'b10100,
                 'b10000};
  int eb [9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int         starts, wus, since, found, cnt;
    logic [7:0] lay_seq, fwd_seq;
    logic [3:0] ep_seq;
    logic       got_wu, saw_bwd;

    #2 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_a_ctl", a_ctl(), 0);
    chk("rst_a_epoch", int'(a_epoch), 0);
    chk("rst_b_ctl", b_ctl(), 0);

    // Full run, pass_done returned two cycles after each start.
    starts = 0; wus = 0; since = 100; lay_seq = '0; fwd_seq = '0; ep_seq = '0;
    got_wu = 1'b0;
    init = 1'b1;
    step();
    init = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (got_wu) ep_seq = {ep_seq[1:0], a_epoch};
      if (a_done) break;
      if (a_start) begin
        starts++;
        lay_seq = {lay_seq[6:0], a_layer};
        fwd_seq = {fwd_seq[6:0], a_fwd};
        since   = 0;
      end else begin
        since++;
      end
      got_wu = a_wu;
      if (a_wu) wus++;
      pd = (since == 2);
      step();
    end
    pd = 1'b0;
    chk("run_done", int'(a_done), 1);
    chk("run_epoch", int'(a_epoch), 2);
    chk("run_starts", starts, 8);
    chk("run_wu", wus, 2);
    chk("run_layers", int'(lay_seq), 'b01100110);
    chk("run_dirs", int'(fwd_seq), 'b11001100);
    chk("run_epoch_seq", int'(ep_seq), 'b0110);
    chk("run_mdl_epoch", ma.ep, 2);

    // pass_done held high: two-cycle passes; restart of the 1-layer block from DONE.
    abort = 1'b1;
    step();
    abort = 1'b0;
    init  = 1'b1;
    pd    = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("hold_a_ctl", int'({a_fwd, a_bwd, a_start, a_wu, a_done}), ta[k]);
      chk("hold_a_layer", int'(a_layer), la[k]);
      chk("hold_b_ctl", int'({b_fwd, b_bwd, b_start, b_wu, b_done}), tbx[k]);
      chk("hold_b_epoch", int'(b_epoch), eb[k]);
      init = (k == 6);
    end
    chk("hold_a_epoch", int'(a_epoch), 0);

    // Abort together with pass_done in backward layer 1.
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (a_bwd && a_layer == 1'b1 && !a_start) begin
        found = 1;
        break;
      end
    end
    chk("abort_reach", found, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    pd    = 1'b0;
    chk("abort_a_ctl", a_ctl(), 0);
    chk("abort_a_layer", int'(a_layer), 0);
    chk("abort_a_epoch", int'(a_epoch), 0);
    chk("abort_b_ctl", b_ctl(), 0);
    chk("abort_mdl", int'(ma.act), 0);

    // en low for five cycles across a start pulse.
    init = 1'b1;
    step();
    chk("en_first_start", int'(a_start), 1);
    init = 1'b0;
    en   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("en_hold_start", int'(a_start), 1);
      chk("en_hold_fwd", int'(a_fwd), 1);
    end
    en  = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (a_start) cnt++;
    end
    chk("en_no_dup", cnt, 0);
    chk("en_still_fwd", int'(a_fwd), 1);

`ifdef TRAIN_SEQ_EARLY_STOP_EN
    // Zero loss at the end of the first epoch's forward passes.
    abort = 1'b1;
    step();
    abort   = 1'b0;
    init    = 1'b1;
    pd      = 1'b1;
    lz      = 1'b1;
    saw_bwd = 1'b0;
    cnt     = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      init = 1'b0;
      if (a_bwd) saw_bwd = 1'b1;
      if (a_wu && a_zl) cnt++;
    end
    pd = 1'b0;
    lz = 1'b0;
    chk("early_no_bwd", int'(saw_bwd), 0);
    chk("early_upd", cnt, 1);
    chk("early_epoch", int'(a_epoch), 1);
    chk("early_done", int'(a_done), 1);
`else
    saw_bwd = 1'b0;
`endif

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 9) != 0);
      init  = ($urandom_range(0, 9) == 0);
      abort = ($urandom_range(0, 79) == 0);
      pd    = ($urandom_range(0, 9) < 4);
      lz    = ($urandom_range(0, 2) == 0);
      step();
    end
    en = 1'b1; init = 1'b0; abort = 1'b0; pd = 1'b0; lz = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
